priority_encoder_rr: RTL and testbench

Parametrised, registered N-to-log2(N) encoder with a valid/ready handshake on both sides. It generalises the one-hot 8-to-3 encoder. Multi-hot inputs resolve by fixed (LSB-first) or round-robin priority instead of producing X, and all-zero and multi-hot inputs are flagged explicitly. It sits between request-gathering logic and any consumer that needs a binary index, such as an arbiter grant path or a mux select.

---
 rtl/priority_encoder_rr.sv | 97 +++++++++
 tb/tb_priority_encoder_rr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder_rr.sv
// rtl/priority_encoder_rr.sv - registered N-to-log2(N) encoder with fixed or round-robin priority and valid/ready handshake
module priority_encoder_rr #(
    parameter int WIDTH   = 8,
    parameter int OUT_W   = $clog2(WIDTH),
    parameter int RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] code_out,
    output logic             zero,
    output logic             multi_hot
);
    localparam int PTR_W = $clog2(WIDTH);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] code_q, code_d;
    logic             zero_q, zero_d;
    logic             multi_hot_q, multi_hot_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic             accept;
    logic             found;
    int               sel;
    int               start_idx;
    int               scan_idx;
    logic [WIDTH-1:0] shifted;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Scan WIDTH positions starting at the priority pointer, wrapping past WIDTH-1.
    always_comb begin
        start_idx = (RR_MODE != 0) ? int'(ptr_q) : 0;
        sel       = 0;
        found     = 1'b0;
        scan_idx  = 0;
        shifted   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            scan_idx = start_idx + k;
            if (scan_idx >= WIDTH) begin
                scan_idx = scan_idx - WIDTH;
            end
            shifted = data_in >> scan_idx;
            if (!found && shifted[0]) begin
                sel   = scan_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        code_d      = code_q;
        zero_d      = zero_q;
        multi_hot_d = multi_hot_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            code_d      = OUT_W'(sel);
            zero_d      = (data_in == '0);
            // Clearing the lowest set bit leaves something only when two or more were set.
            multi_hot_d = |(data_in & (data_in - WIDTH'(1)));
            if ((RR_MODE != 0) && found) begin
                ptr_d = (sel == WIDTH - 1) ? '0 : PTR_W'(sel + 1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            code_q      <= '0;
            zero_q      <= 1'b0;
            multi_hot_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            zero_q      <= zero_d;
            multi_hot_q <= multi_hot_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign zero      = zero_q;
    assign multi_hot = multi_hot_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// tb/tb_priority_encoder_rr.sv - scoreboard bench for fixed/rr width-8 and rr width-5 encoders
module tb_priority_encoder_rr;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] data_in;
    logic       out_ready;

    logic [2:0] ov;
    logic [2:0] ir;
    logic [2:0] zr;
    logic [2:0] mh;
    logic [2:0] cd0, cd1, cd2;
    logic [4:0] got [3];

    int errors = 0;
    int checks = 0;

    logic [14:0] sb[$];
    int          ptr_m [3];
    logic [4:0]  prev_got [3];
    bit          hold_prev = 0;

    priority_encoder_rr #(.WIDTH(8), .OUT_W(3), .RR_MODE(0)) u_fix8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .data_in(data_in), .out_valid(ov[0]), .out_ready(out_ready),
        .code_out(cd0), .zero(zr[0]), .multi_hot(mh[0]));

    priority_encoder_rr #(.WIDTH(8), .OUT_W(3), .RR_MODE(1)) u_rr8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .data_in(data_in), .out_valid(ov[1]), .out_ready(out_ready),
        .code_out(cd1), .zero(zr[1]), .multi_hot(mh[1]));

    priority_encoder_rr #(.WIDTH(5), .OUT_W(3), .RR_MODE(1)) u_rr5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .data_in(data_in[4:0]), .out_valid(ov[2]), .out_ready(out_ready),
        .code_out(cd2), .zero(zr[2]), .multi_hot(mh[2]));

    assign got[0] = {cd0, zr[0], mh[0]};
    assign got[1] = {cd1, zr[1], mh[1]};
    assign got[2] = {cd2, zr[2], mh[2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search positions in priority order and take the first request found.
    function automatic logic [4:0] ref_result(input int w, input bit rr, input logic [7:0] d,
                                              inout int p);
        logic [7:0] dm;
        int         s;
        int         idx;
        bit         hit;
        dm  = d & ((8'd1 << w) - 8'd1);
        s   = 0;
        hit = 0;
        for (int j = 0; j < w; j++) begin
            idx = rr ? (p + j) % w : j;
            if (!hit && dm[idx]) begin
                s   = idx;
                hit = 1;
            end
        end
        if (hit && rr) p = (s + 1) % w;
        return {3'(s), dm == 8'd0, $countones(dm) >= 2};
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [14:0] e;
        int          p;
        if (!rst_n) begin
            sb.delete();
            for (int k = 0; k < 3; k++) ptr_m[k] = 0;
            hold_prev = 0;
        end else begin
            for (int k = 0; k < 3; k++)
                check("in_ready", k, 32'(ir[k]), 32'(!ov[k] || out_ready));
            if (hold_prev) begin
                for (int k = 0; k < 3; k++) begin
                    check("hold_valid", k, 32'(ov[k]), 32'd1);
                    check("hold_stable", k, 32'(got[k]), 32'(prev_got[k]));
                end
            end
            if (ov[0] && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got out_valid=1 want no pending output at %0t", $time);
                end else begin
                    e = sb.pop_front();
                    check("result", 0, 32'(got[0]), 32'(e[4:0]));
                    check("result", 1, 32'(got[1]), 32'(e[9:5]));
                    check("result", 2, 32'(got[2]), 32'(e[14:10]));
                    check("valid_agree", 1, 32'(ov[1]), 32'd1);
                    check("valid_agree", 2, 32'(ov[2]), 32'd1);
                end
            end
            if (in_valid && ir[0]) begin
                p = ptr_m[0]; e[4:0]   = ref_result(8, 0, data_in, p); ptr_m[0] = p;
                p = ptr_m[1]; e[9:5]   = ref_result(8, 1, data_in, p); ptr_m[1] = p;
                p = ptr_m[2]; e[14:10] = ref_result(5, 1, data_in, p); ptr_m[2] = p;
                sb.push_back(e);
            end
            hold_prev = ov[0] && !out_ready;
            for (int k = 0; k < 3; k++) prev_got[k] = got[k];
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        in_valid  = v;
        data_in   = d;
        out_ready = r;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 8'h00, 1);
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 8'h10, 1);
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            for (int k = 0; k < 3; k++) begin
                check("rst_valid", k, 32'(ov[k]), 32'd0);
                check("rst_outputs", k, 32'(got[k]), 32'd0);
                check("rst_in_ready", k, 32'(ir[k]), 32'd1);
            end
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(1, 8'(1 << i), 1);
            cyc(1);
        end
        drive(1, 8'hA4, 1); cyc(1);
        drive(1, 8'h00, 1); cyc(1);
        drive(0, 8'h00, 1); cyc(2);

        do_reset();
        repeat (4) begin
            drive(1, 8'h91, 1);
            cyc(1);
        end
        drive(0, 8'h00, 1); cyc(2);

        do_reset();
        repeat (3) begin
            drive(1, 8'h11, 1);
            cyc(1);
        end
        drive(0, 8'h00, 1); cyc(2);

        do_reset();
        drive(1, 8'h08, 1); cyc(1);
        drive(1, 8'h40, 0); cyc(4);
        drive(1, 8'h40, 1); cyc(1);
        drive(0, 8'h00, 1); cyc(2);

        do_reset();
        drive(1, 8'h10, 1); cyc(1);
        drive(0, 8'h00, 0); cyc(1);
        rst_n = 1'b0; cyc(1);
        rst_n = 1'b1;
        drive(1, 8'h21, 1); cyc(1);
        check("midreset_code", 1, 32'(cd1), 32'd0);
        check("midreset_valid", 1, 32'(ov[1]), 32'd1);
        drive(0, 8'h00, 1); cyc(2);

        for (int c = 0; c < 500; c++) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'(1 << $urandom_range(0, 7));
                default: d = 8'($urandom);
            endcase
            rst_n = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0);
            cyc(1);
        end

        rst_n = 1'b1;
        drive(0, 8'h00, 1);
        cyc(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
